hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Pipeline hazard and stall controller for the 5-stage MIPS datapath. It produces the write-enable, flush and bubble controls consumed by the PC, the IF/ID register (IF_ID_Write) and the ID/EX register. It decodes the instruction held in IF/ID and keeps its own shadow of load instructions in EX and MEM to detect load-use hazards. It also freezes the pipe while data memory is busy and counts stall cycles.

## Interface
Parameters:
- LOAD_LAT, 1, load-use bubbles required: 1 means MEM→EX forwarding exists, 2 means none (the MEM-stage load is also checked).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- instr_id  input  32  instruction currently in ID (IF/ID Instruction_out).
- branch_taken  input  1  branch/jump resolved taken in ID this cycle.
- mem_busy  input  1  data memory not ready; whole pipe must hold.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID write enable (IF_ID_Write).
- if_id_flush  output  1  IF/ID loads a NOP (0x00000000) this edge.
- id_ex_write  output  1  ID/EX (and later stages) write enable.
- ctrl_bubble  output  1  zero all control fields entering ID/EX.
- state  output  2  RUN=0, STALL=1, WAIT=2.
- stall_cnt  output  CNT_W  saturating count of cycles with pc_write=0.

## Operation
- Decode of instr_id:
  - rs=[25:21], rt=[20:16], op=[31:26].
  - is_lw: op==6'b100011.
  - uses_rt: op is 000000 (R-type), 000100 (beq), 000101 (bne) or 101011 (sw).
- Shadow pipeline:
  - Two entries, EX and MEM, each holding {memread, rt}.
  - Updates on an edge where id_ex_write=1.
  - EX entry loads {is_lw & ~ctrl_bubble, ctrl_bubble ? 0 : rt}.
  - MEM entry loads the old EX entry.
  - Holds when id_ex_write=0.
- match(e): e.memread && e.rt!=0 && (e.rt==rs || (uses_rt && e.rt==rt)).
- load_use: match(EX), or, when LOAD_LAT==2, match(MEM).
- Output priority (combinational from current state, shadow and inputs):
  1. mem_busy=1 → freeze: pc_write=0, if_id_write=0, id_ex_write=0, ctrl_bubble=0, if_id_flush=0.
  2. load_use → stall: pc_write=0, if_id_write=0, id_ex_write=1, ctrl_bubble=1, if_id_flush=0. Any concurrent branch_taken is ignored; the branch re-asserts after the stall.
  3. branch_taken → all writes 1, if_id_flush=1, ctrl_bubble=0.
  4. otherwise → all writes 1, flush=0, bubble=0.
- State machine (next state uses the same priority):
  - Priority 1 → WAIT.
  - Priority 2 → STALL.
  - Otherwise → RUN.
  - State is informational; outputs do not depend on it beyond the above. Leaving WAIT needs no extra cycle: with mem_busy=0 in WAIT, the RUN rules apply in that same cycle.
- stall_cnt:
  - Increments on every edge where pc_write=0.
  - Saturates at all-ones and never wraps.
- Reset (rst=0, asynchronous):
  - Shadow entries cleared to {0,0}, state=RUN, stall_cnt=0.
  - With mem_busy=0 and branch_taken=0, outputs read pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=0, ctrl_bubble=0.
  - Reset mid-stall or mid-wait drops any pending hazard immediately.

## Timing
- Zero-latency control: outputs respond combinationally in the cycle the hazard is visible in ID.
- Load-use penalty:
  - LOAD_LAT=1: exactly 1 bubble.
  - LOAD_LAT=2: exactly 2 bubbles when the dependent instruction directly follows the load; 1 bubble if one independent instruction separates them.
- Freeze interaction:
  - A mem_busy freeze does not advance the shadow, so a load-use stall pending before the freeze resumes after it with its full bubble count.
  - A freeze of N cycles adds exactly N to stall_cnt.
- Branch flush costs 1 cycle and does not touch stall_cnt.

## Test plan
- Reset: drive rst=0 mid-stall → state=RUN, stall_cnt=0, writes=1 immediately. Release, NOP stream → no stalls for 10 cycles.
- Load-use, LOAD_LAT=1: lw $2,0($1) then add $3,$2,$4 → one cycle with pc_write=0 and ctrl_bubble=1; stall_cnt=1; add enters EX next edge.
- LOAD_LAT=2: lw $5 followed by sw $5 (rt use) → two consecutive bubbles, stall_cnt=2. Same pair with lw $0 → no stall.
- Memory wait: mem_busy high 3 cycles during a load-use stall → 3 freeze cycles (state=WAIT), then the 1 remaining bubble; stall_cnt=4.
- Branch: branch_taken=1 with no hazard → if_id_flush=1 for one cycle, writes stay 1. Branch_taken coinciding with load_use → flush=0, bubble=1.
- Saturation: CNT_W=4, hold mem_busy 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Control bundle between the hazard controller and the datapath.
// Datapath side drives ID decode and memory status, controller drives enables.
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr_id;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             ctrl_bubble;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output instr_id, branch_taken, mem_busy,
        input  pc_write, if_id_write, if_id_flush,
        input  id_ex_write, ctrl_bubble, state, stall_cnt
    );

    modport slave (
        input  instr_id, branch_taken, mem_busy,
        output pc_write, if_id_write, if_id_flush,
        output id_ex_write, ctrl_bubble, state, stall_cnt
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use stall, branch flush and memory-wait freeze for the 5-stage pipe.
// Keeps a shadow of loads in EX/MEM and counts PC-hold cycles.
module hazard_stall_controller #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    hazard_stall_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_ex_mr;
    logic [4:0]       r_ex_rt;
    logic             r_mem_mr;
    logic [4:0]       r_mem_rt;
    logic [CNT_W-1:0] r_cnt;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_is_lw;
    logic       w_uses_rt;
    logic       w_ex_hit;
    logic       w_mem_hit;
    logic       w_load_use;
    logic       w_pc_write;
    logic       w_if_id_write;
    logic       w_flush;
    logic       w_id_ex_write;
    logic       w_bubble;

    assign w_op    = bus.instr_id[31:26];
    assign w_rs    = bus.instr_id[25:21];
    assign w_rt    = bus.instr_id[20:16];
    assign w_is_lw = (w_op == 6'b100011);

    assign w_uses_rt = (w_op == 6'b000000) ||
                       (w_op == 6'b000100) ||
                       (w_op == 6'b000101) ||
                       (w_op == 6'b101011);

    assign w_ex_hit = r_ex_mr && (r_ex_rt != 5'd0) &&
                      ((r_ex_rt == w_rs) ||
                       (w_uses_rt && (r_ex_rt == w_rt)));

    assign w_mem_hit = r_mem_mr && (r_mem_rt != 5'd0) &&
                       ((r_mem_rt == w_rs) ||
                        (w_uses_rt && (r_mem_rt == w_rt)));

    // Without MEM->EX forwarding the MEM-stage load also blocks
    assign w_load_use = w_ex_hit || ((LOAD_LAT == 2) && w_mem_hit);

    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_id_ex_write = 1'b1;
        w_flush       = 1'b0;
        w_bubble      = 1'b0;
        w_next        = RUN;
        if (bus.mem_busy) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_write = 1'b0;
            w_next        = WAIT;
        end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
            w_next        = STALL;
        end else if (bus.branch_taken) begin
            w_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex_mr  <= 1'b0;
            r_ex_rt  <= 5'd0;
            r_mem_mr <= 1'b0;
            r_mem_rt <= 5'd0;
        end else if (w_id_ex_write) begin
            r_ex_mr  <= w_is_lw && !w_bubble;
            r_ex_rt  <= w_bubble ? 5'd0 : w_rt;
            r_mem_mr <= r_ex_mr;
            r_mem_rt <= r_ex_rt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!w_pc_write && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.pc_write    = w_pc_write;
    assign bus.if_id_write = w_if_id_write;
    assign bus.if_id_flush = w_flush;
    assign bus.id_ex_write = w_id_ex_write;
    assign bus.ctrl_bubble = w_bubble;
    assign bus.state       = r_state;
    assign bus.stall_cnt   = r_cnt;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller in three configurations.
// Instruction-level pipeline model predicts every cycle's controls.
module tb_hazard_stall_controller;
    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        br;
    logic        busy;

    hazard_stall_controller_if #(.CNT_W(16)) if1 ();
    hazard_stall_controller_if #(.CNT_W(16)) if2 ();
    hazard_stall_controller_if #(.CNT_W(4))  if3 ();

    assign if1.instr_id     = instr;
    assign if1.branch_taken = br;
    assign if1.mem_busy     = busy;
    assign if2.instr_id     = instr;
    assign if2.branch_taken = br;
    assign if2.mem_busy     = busy;
    assign if3.instr_id     = instr;
    assign if3.branch_taken = br;
    assign if3.mem_busy     = busy;

    hazard_stall_controller #(.LOAD_LAT(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .bus(if1));
    hazard_stall_controller #(.LOAD_LAT(2), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .bus(if2));
    hazard_stall_controller #(.LOAD_LAT(1), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        pcw;
        logic        ifw;
        logic        fl;
        logic        idw;
        logic        bub;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int errs = 0;
    int checks = 0;

    // Model: the actual instructions sitting in EX and MEM per config
    logic [31:0] m_ex[3];
    logic [31:0] m_mem[3];
    logic [1:0]  m_st[3];
    int          m_cnt[3];
    int          lat[3]  = '{1, 2, 1};
    int          cmax[3] = '{65535, 65535, 15};

    logic [31:0] prog[$];
    logic [31:0] cur;

    function automatic logic reads(logic [31:0] ld,
                                   logic [31:0] id);
        logic [4:0] d;
        logic       rt_src;
        if (ld[31:26] != 6'b100011) return 1'b0;
        d = ld[20:16];
        if (d == 5'd0) return 1'b0;
        rt_src = (id[31:26] == 6'b000000) ||
                 (id[31:26] == 6'b000100) ||
                 (id[31:26] == 6'b000101) ||
                 (id[31:26] == 6'b101011);
        return (id[25:21] == d) || (rt_src && id[20:16] == d);
    endfunction

    function automatic logic hazard(int k, logic [31:0] id);
        logic h;
        h = reads(m_ex[k], id);
        if (lat[k] >= 2) h = h || reads(m_mem[k], id);
        return h;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [5:0] ops[6];
        ops = '{6'b100011, 6'b000000, 6'b000100,
                6'b000101, 6'b101011, 6'b001000};
        return {ops[$urandom_range(0, 5)],
                5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)),
                16'($urandom)};
    endfunction

    function automatic logic [31:0] lw(int rs, int rt);
        return {6'b100011, 5'(rs), 5'(rt), 16'd0};
    endfunction

    function automatic logic [31:0] rtype(int rs, int rt, int rd);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 11'h020};
    endfunction

    function automatic logic [31:0] sw(int rs, int rt);
        return {6'b101011, 5'(rs), 5'(rt), 16'd4};
    endfunction

    task automatic step(input logic b, input logic bri,
                        input logic r);
        exp_t e;
        exp_t e_hold;
        logic h;
        @(posedge clk);
        #1;
        rst   = r;
        busy  = b;
        br    = bri;
        instr = cur;
        e_hold = '0;
        for (int k = 0; k < 3; k++) begin
            if (!r) begin
                m_ex[k]  = 32'd0;
                m_mem[k] = 32'd0;
                m_st[k]  = 2'd0;
                m_cnt[k] = 0;
            end
            h = hazard(k, cur);
            e.st  = m_st[k];
            e.cnt = 16'(m_cnt[k]);
            e.fl  = 1'b0;
            e.bub = 1'b0;
            if (b) begin
                {e.pcw, e.ifw, e.idw} = 3'b000;
            end else if (h) begin
                {e.pcw, e.ifw, e.idw} = 3'b001;
                e.bub = 1'b1;
            end else begin
                {e.pcw, e.ifw, e.idw} = 3'b111;
                e.fl = bri;
            end
            if (k == 0) q0.push_back(e);
            if (k == 1) q1.push_back(e);
            if (k == 2) q2.push_back(e);
            if (k == 1) e_hold = e;
            if (r) begin
                if (!e.pcw && m_cnt[k] < cmax[k])
                    m_cnt[k] = m_cnt[k] + 1;
                if (b) begin
                    m_st[k] = 2'd2;
                end else begin
                    m_mem[k] = m_ex[k];
                    m_ex[k]  = h ? 32'd0 : cur;
                    m_st[k]  = h ? 2'd1 : 2'd0;
                end
            end
        end
        if (e_hold.fl) begin
            cur = 32'd0;
        end else if (e_hold.ifw || !r) begin
            cur = (prog.size() > 0) ? prog.pop_front() : 32'd0;
        end
    endtask

    task automatic chk(input int k, input exp_t e, input exp_t a);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL ctl_dut%0d t=%0t got pcw%b ifw%b fl%b idw%b bub%b st%0d cnt%0d need pcw%b ifw%b fl%b idw%b bub%b st%0d cnt%0d",
                     k, $time, a.pcw, a.ifw, a.fl, a.idw, a.bub,
                     a.st, a.cnt, e.pcw, e.ifw, e.fl, e.idw,
                     e.bub, e.st, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        exp_t a;
        if (q0.size() > 0) begin
            a = {if1.pc_write, if1.if_id_write, if1.if_id_flush,
                 if1.id_ex_write, if1.ctrl_bubble, if1.state,
                 if1.stall_cnt};
            chk(1, q0.pop_front(), a);
        end
        if (q1.size() > 0) begin
            a = {if2.pc_write, if2.if_id_write, if2.if_id_flush,
                 if2.id_ex_write, if2.ctrl_bubble, if2.state,
                 if2.stall_cnt};
            chk(2, q1.pop_front(), a);
        end
        if (q2.size() > 0) begin
            a = {if3.pc_write, if3.if_id_write, if3.if_id_flush,
                 if3.id_ex_write, if3.ctrl_bubble, if3.state,
                 16'(if3.stall_cnt)};
            chk(3, q2.pop_front(), a);
        end
    end

    initial begin
        rst   = 1'b0;
        busy  = 1'b0;
        br    = 1'b0;
        instr = 32'd0;
        cur   = 32'd0;
        for (int k = 0; k < 3; k++) begin
            m_ex[k] = 0; m_mem[k] = 0; m_st[k] = 0; m_cnt[k] = 0;
        end
        step(0, 0, 0);
        step(0, 0, 0);

        prog.push_back(lw(1, 2));
        prog.push_back(rtype(2, 4, 3));
        for (int i = 0; i < 6; i++) step(0, 0, 1);

        prog.push_back(sw(0, 5));
        cur = lw(1, 5);
        for (int i = 0; i < 6; i++) step(0, 0, 1);
        prog.push_back(sw(0, 0));
        cur = lw(1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1);

        prog.push_back(rtype(2, 4, 3));
        cur = lw(1, 2);
        step(0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1);

        step(0, 1, 1);
        step(0, 0, 1);
        prog.push_back(rtype(2, 4, 3));
        cur = lw(1, 2);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 1, 1);
        step(0, 0, 1);

        prog.push_back(rtype(2, 4, 3));
        cur = lw(1, 2);
        step(0, 0, 1);
        step(0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1);

        for (int i = 0; i < 20; i++) step(1, 0, 1);
        step(0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            if (prog.size() == 0) prog.push_back(rnd_instr());
            step(($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) != 0));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errs++;
            $display("FAIL drain got %0d pending need 0",
                     q0.size() + q1.size() + q2.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
